// File: rtl/clk_div_pkg.sv
// Shared constants, rate-select encodings and divisor lookup for the programmable divider.
package clk_div_pkg;

  localparam int unsigned DEF_DIV0 = 25_000_000;
  localparam int unsigned DEF_DIV1 = 2_500_000;
  localparam int unsigned DEF_DIV2 = 25_000;
  localparam int unsigned DEF_DIV3 = 500_000;

  typedef enum logic [1:0] {
    SEL_1HZ  = 2'b00,
    SEL_10HZ = 2'b01,
    SEL_1KHZ = 2'b10,
    SEL_50HZ = 2'b11
  } sel_e;

  function automatic int unsigned div_lookup(input sel_e sel, input int unsigned d0,
                                             input int unsigned d1, input int unsigned d2,
                                             input int unsigned d3);
    int unsigned div;
    div = d0;
    unique case (sel)
      SEL_1HZ:  div = d0;
      SEL_10HZ: div = d1;
      SEL_1KHZ: div = d2;
      SEL_50HZ: div = d3;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle between a controller and the programmable divider.
interface clk_div_prog_if;

  logic [1:0] sel;
  logic       run_tgl;
  logic       oneshot;
  logic       clr;
  logic       clk_out;
  logic       tick;
  logic       running;

  modport master (
    output sel, run_tgl, oneshot, clr,
    input  clk_out, tick, running
  );

  modport slave (
    input  sel, run_tgl, oneshot, clr,
    output clk_out, tick, running
  );

endinterface

// File: rtl/edge_rise.sv
// Rising-edge detector for level requests; a held-high level yields one pulse.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/clk_div_prog.sv
// Programmable 50%-duty divider with run/pause toggle, one-shot mode and
// glitch-free rate changes applied on full-period boundaries.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned DIV0  = DEF_DIV0,
  parameter int unsigned DIV1  = DEF_DIV1,
  parameter int unsigned DIV2  = DEF_DIV2,
  parameter int unsigned DIV3  = DEF_DIV3
) (
  input  logic           clk,
  input  logic           rst,
  clk_div_prog_if.slave  bus
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  sel_e             sel_q, sel_d;

  logic [CNT_W-1:0] lim;
  logic             tgl_rise;
  logic             tc;
  logic             fall;
  logic             os_stop;

  edge_rise u_run_edge (
    .clk     (clk),
    .rst     (rst),
    .level_i (bus.run_tgl),
    .rise_o  (tgl_rise)
  );

  assign lim     = CNT_W'(div_lookup(sel_q, DIV0, DIV1, DIV2, DIV3) - 1);
  assign tc      = running_q && (cnt_q == lim);
  assign fall    = tc && clk_out_q;
  // Clear overrides the one-shot stop; a same-cycle toggle cancels it.
  assign os_stop = !bus.clr && fall && bus.oneshot;

  always_comb begin
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    sel_d     = sel_q;
    running_d = running_q;

    if (bus.clr) begin
      cnt_d     = '0;
      clk_out_d = 1'b0;
      sel_d     = sel_e'(bus.sel);
    end else if (running_q) begin
      if (tc) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
        tick_d    = 1'b1;
        // New rate is only latched at the end of a full high+low period.
        if (clk_out_q) begin
          sel_d = sel_e'(bus.sel);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      sel_d = sel_e'(bus.sel);
    end

    if (os_stop) begin
      running_d = tgl_rise;
    end else if (tgl_rise) begin
      running_d = ~running_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      sel_q     <= SEL_1HZ;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      sel_q     <= sel_d;
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;
  assign bus.running = running_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with small divisors (3/5/2/1) and hand-computed traces.
module tb_clk_div_prog;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  logic [23:0] co_v, tk_v, rn_v;

  clk_div_prog_if dif ();

  clk_div_prog #(
    .CNT_W (8),
    .DIV0  (3),
    .DIV1  (5),
    .DIV2  (2),
    .DIV3  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Records n post-edge samples; the first sample ends up in the most significant used bit.
  task automatic capture(input int n, output logic [23:0] co, output logic [23:0] tk,
                         output logic [23:0] rn);
    co = '0;
    tk = '0;
    rn = '0;
    for (int i = 0; i < n; i++) begin
      step();
      co = {co[22:0], dif.clk_out};
      tk = {tk[22:0], dif.tick};
      rn = {rn[22:0], dif.running};
    end
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    rst         = 1'b1;
    dif.sel     = 2'b00;
    dif.run_tgl = 1'b0;
    dif.oneshot = 1'b0;
    dif.clr     = 1'b0;

    // Reset state and idle after release
    step();
    step();
    chk("rst_clk_out", 32'(dif.clk_out), 32'd0);
    chk("rst_tick", 32'(dif.tick), 32'd0);
    chk("rst_running", 32'(dif.running), 32'd0);
    rst = 1'b0;
    step();
    step();
    chk("idle_clk_out", 32'(dif.clk_out), 32'd0);
    chk("idle_running", 32'(dif.running), 32'd0);

    // Basic rate: DIV0=3 -> high 3 / low 3, tick every 3
    dif.run_tgl = 1'b1;
    capture(22, co_v, tk_v, rn_v);
    chk("basic_clk_out", 32'(co_v), 32'(22'b0001110001110001110001));
    chk("basic_tick", 32'(tk_v), 32'(22'b0001001001001001001001));
    chk("basic_running", 32'(rn_v), 32'(22'h3fffff));

    // Rate switch while high: finish at 3, then half-periods of 5
    dif.sel     = 2'b01;
    dif.run_tgl = 1'b0;
    capture(24, co_v, tk_v, rn_v);
    chk("switch_clk_out", 32'(co_v), 32'(24'b110000011111000001111100));
    chk("switch_tick", 32'(tk_v), 32'(24'b001000010000100001000010));

    // Pause, hold 10 cycles, resume
    dif.run_tgl = 1'b1;
    step();
    chk("pause_running", 32'(dif.running), 32'd0);
    capture(10, co_v, tk_v, rn_v);
    chk("pause_clk_out", 32'(co_v), 32'd0);
    chk("pause_tick", 32'(tk_v), 32'd0);
    chk("pause_held_running", 32'(rn_v), 32'd0);
    dif.run_tgl = 1'b0;
    step();
    dif.run_tgl = 1'b1;
    capture(6, co_v, tk_v, rn_v);
    chk("resume_clk_out", 32'(co_v), 32'(6'b000111));
    chk("resume_tick", 32'(tk_v), 32'(6'b000100));
    chk("resume_running", 32'(rn_v), 32'(6'b111111));

    // Toggle on a TC cycle: TC action completes, then running drops
    dif.run_tgl = 1'b0;
    step();
    step();
    dif.run_tgl = 1'b1;
    step();
    chk("coll_clk_out", 32'(dif.clk_out), 32'd0);
    chk("coll_tick", 32'(dif.tick), 32'd1);
    chk("coll_running", 32'(dif.running), 32'd0);
    step();
    chk("coll_tick_after", 32'(dif.tick), 32'd0);

    // clr on the TC cycle suppresses the edge and restarts the count
    dif.run_tgl = 1'b0;
    dif.sel     = 2'b00;
    step();
    dif.run_tgl = 1'b1;
    step();
    chk("clr_start_running", 32'(dif.running), 32'd1);
    step();
    step();
    dif.clr = 1'b1;
    step();
    chk("clr_clk_out", 32'(dif.clk_out), 32'd0);
    chk("clr_tick", 32'(dif.tick), 32'd0);
    chk("clr_running", 32'(dif.running), 32'd1);
    dif.clr = 1'b0;
    capture(3, co_v, tk_v, rn_v);
    chk("clr_after_clk_out", 32'(co_v), 32'(3'b001));
    chk("clr_after_tick", 32'(tk_v), 32'(3'b001));

    // One-shot at DIV3=1: high 1, low 1, stop; held run_tgl does not restart
    dif.run_tgl = 1'b0;
    step();
    dif.run_tgl = 1'b1;
    step();
    dif.clr = 1'b1;
    dif.sel = 2'b11;
    step();
    dif.clr     = 1'b0;
    dif.oneshot = 1'b1;
    dif.run_tgl = 1'b0;
    step();
    dif.run_tgl = 1'b1;
    capture(8, co_v, tk_v, rn_v);
    chk("os_running", 32'(rn_v), 32'(8'b11000000));
    chk("os_clk_out", 32'(co_v), 32'(8'b01000000));
    chk("os_tick", 32'(tk_v), 32'(8'b01100000));

    // Toggle coinciding with one-shot stop keeps running
    dif.run_tgl = 1'b0;
    step();
    dif.run_tgl = 1'b1;
    step();
    chk("os2_start", 32'(dif.running), 32'd1);
    dif.run_tgl = 1'b0;
    step();
    chk("os2_rise_clk_out", 32'(dif.clk_out), 32'd1);
    dif.run_tgl = 1'b1;
    capture(4, co_v, tk_v, rn_v);
    chk("os2_running", 32'(rn_v), 32'(4'b1100));
    chk("os2_clk_out", 32'(co_v), 32'(4'b0100));
    chk("os2_tick", 32'(tk_v), 32'(4'b1110));

    // Async reset between clock edges
    dif.oneshot = 1'b0;
    dif.run_tgl = 1'b0;
    dif.sel     = 2'b00;
    step();
    dif.run_tgl = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    chk("prerst_clk_out", 32'(dif.clk_out), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_clk_out", 32'(dif.clk_out), 32'd0);
    chk("arst_tick", 32'(dif.tick), 32'd0);
    chk("arst_running", 32'(dif.running), 32'd0);
    dif.run_tgl = 1'b0;
    step();
    step();
    #3;
    rst = 1'b0;
    capture(5, co_v, tk_v, rn_v);
    chk("postrst_clk_out", 32'(co_v), 32'd0);
    chk("postrst_tick", 32'(tk_v), 32'd0);
    chk("postrst_running", 32'(rn_v), 32'd0);
    dif.run_tgl = 1'b1;
    step();
    chk("postrst_restart", 32'(dif.running), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
